// File: rtl/ex_operand_if.sv
// Decode-to-execute stage bus: decode handshake, forwarding taps, flush and ALU-side outputs.
// The stage connects through the slave modport; the producer/consumer side uses master.
interface ex_operand_if #(
  parameter int unsigned N  = 8,
  parameter int unsigned RA = 4
);
  logic          in_valid;
  logic          in_ready;
  logic [4:0]    in_alu_ctrl;
  logic [RA-1:0] in_rs1;
  logic [RA-1:0] in_rs2;
  logic [RA-1:0] in_rd;
  logic [N-1:0]  in_rs1_data;
  logic [N-1:0]  in_rs2_data;
  logic [N-1:0]  in_imm;
  logic          in_use_imm;
  logic          in_wr_en;
  logic          mem_fwd_en;
  logic [RA-1:0] mem_fwd_rd;
  logic [N-1:0]  mem_fwd_data;
  logic          wb_fwd_en;
  logic [RA-1:0] wb_fwd_rd;
  logic [N-1:0]  wb_fwd_data;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [4:0]    alu_ctrl;
  logic [N-1:0]  src_A;
  logic [N-1:0]  src_B;
  logic [RA-1:0] out_rd;
  logic          out_wr_en;
  logic          out_is_load;
  logic          out_is_store;
  logic [N-1:0]  out_store_data;

  modport master (
    output in_valid, in_alu_ctrl, in_rs1, in_rs2, in_rd, in_rs1_data, in_rs2_data, in_imm,
           in_use_imm, in_wr_en, mem_fwd_en, mem_fwd_rd, mem_fwd_data, wb_fwd_en, wb_fwd_rd,
           wb_fwd_data, flush, out_ready,
    input  in_ready, out_valid, alu_ctrl, src_A, src_B, out_rd, out_wr_en, out_is_load,
           out_is_store, out_store_data
  );

  modport slave (
    input  in_valid, in_alu_ctrl, in_rs1, in_rs2, in_rd, in_rs1_data, in_rs2_data, in_imm,
           in_use_imm, in_wr_en, mem_fwd_en, mem_fwd_rd, mem_fwd_data, wb_fwd_en, wb_fwd_rd,
           wb_fwd_data, flush, out_ready,
    output in_ready, out_valid, alu_ctrl, src_A, src_B, out_rd, out_wr_en, out_is_load,
           out_is_store, out_store_data
  );
endinterface

// File: rtl/ex_operand_stage.sv
// Single-entry decode-to-execute register feeding the ALU, with MEM/WB operand forwarding,
// load-use bubble insertion, valid/ready handshake on both sides and branch flush.
module ex_operand_stage #(
  parameter int unsigned N  = 8,
  parameter int unsigned RA = 4
) (
  input logic         clk,
  input logic         rst_n,
  ex_operand_if.slave bus
);

  localparam logic       ST_EMPTY = 1'b0;
  localparam logic       ST_FULL  = 1'b1;
  localparam logic [4:0] CTRL_LDR = 5'd17;
  localparam logic [4:0] CTRL_STR = 5'd19;

  logic          r_state;
  logic [4:0]    r_ctrl;
  logic [RA-1:0] r_rs1;
  logic [RA-1:0] r_rs2;
  logic [RA-1:0] r_rd;
  logic [N-1:0]  r_op1;
  logic [N-1:0]  r_op2;
  logic [N-1:0]  r_imm;
  logic          r_use_imm;
  logic          r_wr_en;

  logic          w_full;
  logic [N-1:0]  w_op1;
  logic [N-1:0]  w_op2;
  logic          w_is_load;
  logic          w_is_store;
  logic          w_rs2_used;
  logic          w_hazard;
  logic          w_in_ready;
  logic          w_capture;

  always_comb begin
    w_full = (r_state == ST_FULL);

    // MEM is the younger producer, so it takes priority over WB.
    if (bus.mem_fwd_en && (bus.mem_fwd_rd == r_rs1))     w_op1 = bus.mem_fwd_data;
    else if (bus.wb_fwd_en && (bus.wb_fwd_rd == r_rs1))  w_op1 = bus.wb_fwd_data;
    else                                                 w_op1 = r_op1;

    if (bus.mem_fwd_en && (bus.mem_fwd_rd == r_rs2))     w_op2 = bus.mem_fwd_data;
    else if (bus.wb_fwd_en && (bus.wb_fwd_rd == r_rs2))  w_op2 = bus.wb_fwd_data;
    else                                                 w_op2 = r_op2;

    w_is_load  = w_full && (r_ctrl == CTRL_LDR);
    w_is_store = w_full && (r_ctrl == CTRL_STR);

    // With an immediate, rs2 is only read as store data.
    w_rs2_used = !bus.in_use_imm || (bus.in_alu_ctrl == CTRL_STR);
    w_hazard   = w_is_load && bus.in_valid &&
                 ((r_rd == bus.in_rs1) || ((r_rd == bus.in_rs2) && w_rs2_used));

    w_in_ready = bus.flush | ((~w_full | bus.out_ready) & ~w_hazard);
    w_capture  = !bus.flush && bus.in_valid && w_in_ready;
  end

  assign bus.in_ready       = w_in_ready;
  assign bus.out_valid      = w_full;
  assign bus.alu_ctrl       = w_full ? r_ctrl : 5'd0;
  assign bus.src_A          = w_full ? w_op1 : '0;
  assign bus.src_B          = !w_full ? '0 : (r_use_imm ? r_imm : w_op2);
  assign bus.out_store_data = w_full ? w_op2 : '0;
  assign bus.out_rd         = r_rd;
  assign bus.out_wr_en      = r_wr_en;
  assign bus.out_is_load    = w_is_load;
  assign bus.out_is_store   = w_is_store;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_EMPTY;
      r_ctrl    <= '0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_rd      <= '0;
      r_op1     <= '0;
      r_op2     <= '0;
      r_imm     <= '0;
      r_use_imm <= 1'b0;
      r_wr_en   <= 1'b0;
    end else if (bus.flush) begin
      r_state <= ST_EMPTY;
    end else if (w_capture) begin
      r_state   <= ST_FULL;
      r_ctrl    <= bus.in_alu_ctrl;
      r_rs1     <= bus.in_rs1;
      r_rs2     <= bus.in_rs2;
      r_rd      <= bus.in_rd;
      r_op1     <= bus.in_rs1_data;
      r_op2     <= bus.in_rs2_data;
      r_imm     <= bus.in_imm;
      r_use_imm <= bus.in_use_imm;
      r_wr_en   <= bus.in_wr_en;
    end else if (bus.out_ready) begin
      r_state <= ST_EMPTY;
    end else if (w_full) begin
      // Latch forwarded values so a producer retiring mid-stall is not lost.
      r_op1 <= w_op1;
      r_op2 <= w_op2;
    end
  end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed self-checking bench for ex_operand_stage: streaming, forwarding, load-use,
// stall refresh, flush and asynchronous reset.
module tb_ex_operand_stage;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  ex_operand_if #(.N(8), .RA(4)) bus ();

  ex_operand_stage #(.N(8), .RA(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_instr(input logic [4:0] ctrl, input logic [3:0] rs1, input logic [3:0] rs2,
                             input logic [3:0] rd, input logic [7:0] d1, input logic [7:0] d2,
                             input logic [7:0] imm, input logic use_imm, input logic wr_en);
    bus.in_valid    = 1'b1;
    bus.in_alu_ctrl = ctrl;
    bus.in_rs1      = rs1;
    bus.in_rs2      = rs2;
    bus.in_rd       = rd;
    bus.in_rs1_data = d1;
    bus.in_rs2_data = d2;
    bus.in_imm      = imm;
    bus.in_use_imm  = use_imm;
    bus.in_wr_en    = wr_en;
  endtask

  task automatic clear_fwd();
    bus.mem_fwd_en   = 1'b0;
    bus.mem_fwd_rd   = 4'd0;
    bus.mem_fwd_data = 8'd0;
    bus.wb_fwd_en    = 1'b0;
    bus.wb_fwd_rd    = 4'd0;
    bus.wb_fwd_data  = 8'd0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    drive_instr(5'd0, 4'd0, 4'd0, 4'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    clear_fwd();
    #12;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid got %0h want 0", bus.out_valid);
    end
    checks++;
    if (bus.src_A !== 8'd0 || bus.src_B !== 8'd0 || bus.alu_ctrl !== 5'd0) begin
      errors++; $display("FAIL reset_alu got %0h/%0h/%0h want 0/0/0",
                         bus.src_A, bus.src_B, bus.alu_ctrl);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got %0h want 1", bus.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    bus.out_ready = 1'b1;
    drive_instr(5'd1, 4'd1, 4'd2, 4'd7, 8'd5, 8'd3, 8'd0, 1'b0, 1'b1);
    step();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.src_A !== 8'd5 || bus.src_B !== 8'd3 ||
        bus.alu_ctrl !== 5'd1) begin
      errors++; $display("FAIL stream_add got v%0h A%0h B%0h c%0h want v1 A5 B3 c1",
                         bus.out_valid, bus.src_A, bus.src_B, bus.alu_ctrl);
    end
    checks++;
    if (bus.out_rd !== 4'd7 || bus.out_wr_en !== 1'b1) begin
      errors++; $display("FAIL stream_rd got %0h/%0h want 7/1", bus.out_rd, bus.out_wr_en);
    end
    drive_instr(5'd2, 4'd3, 4'd4, 4'd8, 8'd10, 8'd4, 8'd0, 1'b0, 1'b1);
    step();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.src_A !== 8'd10 || bus.src_B !== 8'd4 ||
        bus.alu_ctrl !== 5'd2) begin
      errors++; $display("FAIL stream_b2b got v%0h A%0h B%0h c%0h want v1 A0a B4 c2",
                         bus.out_valid, bus.src_A, bus.src_B, bus.alu_ctrl);
    end
    drive_instr(5'd19, 4'd1, 4'd5, 4'd0, 8'h20, 8'h55, 8'h08, 1'b1, 1'b0);
    step();
    checks++;
    if (bus.out_is_store !== 1'b1 || bus.out_is_load !== 1'b0 || bus.src_A !== 8'h20 ||
        bus.src_B !== 8'h08 || bus.out_store_data !== 8'h55) begin
      errors++; $display("FAIL stream_str got st%0h ld%0h A%0h B%0h sd%0h want 1 0 20 08 55",
                         bus.out_is_store, bus.out_is_load, bus.src_A, bus.src_B,
                         bus.out_store_data);
    end
    bus.in_valid = 1'b0;
    step();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.src_A !== 8'd0 || bus.out_is_store !== 1'b0 ||
        bus.out_store_data !== 8'd0) begin
      errors++; $display("FAIL stream_drain got v%0h A%0h st%0h sd%0h want 0 0 0 0",
                         bus.out_valid, bus.src_A, bus.out_is_store, bus.out_store_data);
    end
  endtask

  task automatic test_forward();
    bus.out_ready = 1'b1;
    drive_instr(5'd1, 4'd2, 4'd3, 4'd9, 8'd9, 8'd1, 8'd0, 1'b0, 1'b1);
    step();
    bus.in_valid = 1'b0;
    #1;
    checks++;
    if (bus.src_A !== 8'd9) begin
      errors++; $display("FAIL fwd_none got %0h want 09", bus.src_A);
    end
    bus.mem_fwd_en = 1'b1; bus.mem_fwd_rd = 4'd2; bus.mem_fwd_data = 8'h40;
    bus.wb_fwd_en  = 1'b1; bus.wb_fwd_rd  = 4'd2; bus.wb_fwd_data  = 8'h11;
    #1;
    checks++;
    if (bus.src_A !== 8'h40) begin
      errors++; $display("FAIL fwd_mem_prio got %0h want 40", bus.src_A);
    end
    bus.mem_fwd_en = 1'b0;
    #1;
    checks++;
    if (bus.src_A !== 8'h11) begin
      errors++; $display("FAIL fwd_wb got %0h want 11", bus.src_A);
    end
    bus.wb_fwd_rd = 4'd3;
    #1;
    checks++;
    if (bus.src_A !== 8'd9 || bus.src_B !== 8'h11 || bus.out_store_data !== 8'h11) begin
      errors++; $display("FAIL fwd_wb_rs2 got A%0h B%0h sd%0h want 09 11 11",
                         bus.src_A, bus.src_B, bus.out_store_data);
    end
    clear_fwd();
    step();
  endtask

  task automatic test_load_use();
    bus.out_ready = 1'b1;
    drive_instr(5'd17, 4'd1, 4'd0, 4'd4, 8'h10, 8'd0, 8'd2, 1'b1, 1'b1);
    step();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_is_load !== 1'b1) begin
      errors++; $display("FAIL lu_load got v%0h ld%0h want 1 1", bus.out_valid,
                         bus.out_is_load);
    end
    // rs2 matches but is an immediate-form non-store: no hazard
    drive_instr(5'd1, 4'd2, 4'd4, 4'd5, 8'd0, 8'd0, 8'd1, 1'b1, 1'b1);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL lu_imm_nohaz got %0h want 1", bus.in_ready);
    end
    drive_instr(5'd1, 4'd4, 4'd5, 4'd6, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1);
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL lu_hazard got %0h want 0", bus.in_ready);
    end
    step();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL lu_bubble got v%0h r%0h want 0 1", bus.out_valid,
                         bus.in_ready);
    end
    step();
    bus.in_valid = 1'b0;
    bus.mem_fwd_en = 1'b1; bus.mem_fwd_rd = 4'd4; bus.mem_fwd_data = 8'h77;
    #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.src_A !== 8'h77 || bus.out_is_load !== 1'b0) begin
      errors++; $display("FAIL lu_fwd got v%0h A%0h ld%0h want 1 77 0", bus.out_valid,
                         bus.src_A, bus.out_is_load);
    end
    clear_fwd();
    step();
  endtask

  task automatic test_stall_refresh();
    bus.out_ready = 1'b0;
    drive_instr(5'd1, 4'd1, 4'd6, 4'd2, 8'd5, 8'h01, 8'd0, 1'b0, 1'b1);
    step();
    bus.in_valid = 1'b0;
    bus.wb_fwd_en = 1'b1; bus.wb_fwd_rd = 4'd6; bus.wb_fwd_data = 8'h22;
    #1;
    checks++;
    if (bus.src_B !== 8'h22) begin
      errors++; $display("FAIL stall_c1 got %0h want 22", bus.src_B);
    end
    step();
    clear_fwd();
    #1;
    checks++;
    if (bus.src_B !== 8'h22 || bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL stall_c2 got B%0h v%0h want 22 1", bus.src_B, bus.out_valid);
    end
    bus.in_valid = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL stall_in_ready got %0h want 0", bus.in_ready);
    end
    bus.in_valid = 1'b0;
    step();
    checks++;
    if (bus.src_B !== 8'h22 || bus.src_A !== 8'd5) begin
      errors++; $display("FAIL stall_c3 got B%0h A%0h want 22 05", bus.src_B, bus.src_A);
    end
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.src_B !== 8'h22 || bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL stall_xfer got B%0h v%0h want 22 1", bus.src_B, bus.out_valid);
    end
    step();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL stall_drain got %0h want 0", bus.out_valid);
    end
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    drive_instr(5'd25, 4'd1, 4'd2, 4'd0, 8'h31, 8'h32, 8'h04, 1'b1, 1'b0);
    step();
    drive_instr(5'd1, 4'd3, 4'd4, 4'd5, 8'h66, 8'h67, 8'd0, 1'b0, 1'b1);
    bus.flush = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.alu_ctrl !== 5'd25) begin
      errors++; $display("FAIL flush_ready got r%0h c%0h want 1 19", bus.in_ready,
                         bus.alu_ctrl);
    end
    step();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.alu_ctrl !== 5'd0 || bus.src_A !== 8'd0) begin
      errors++; $display("FAIL flush_kill got v%0h c%0h A%0h want 0 0 0", bus.out_valid,
                         bus.alu_ctrl, bus.src_A);
    end
    step();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_discard got %0h want 0", bus.out_valid);
    end
  endtask

  task automatic test_async_reset();
    bus.out_ready = 1'b0;
    drive_instr(5'd3, 4'd1, 4'd2, 4'd9, 8'h33, 8'h44, 8'd0, 1'b0, 1'b1);
    step();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.src_A !== 8'h33) begin
      errors++; $display("FAIL areset_pre got v%0h A%0h want 1 33", bus.out_valid, bus.src_A);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.src_A !== 8'd0 || bus.src_B !== 8'd0 ||
        bus.alu_ctrl !== 5'd0 || bus.out_rd !== 4'd0 || bus.out_wr_en !== 1'b0 ||
        bus.out_store_data !== 8'd0) begin
      errors++; $display("FAIL areset_clear got v%0h A%0h B%0h c%0h rd%0h we%0h sd%0h want 0",
                         bus.out_valid, bus.src_A, bus.src_B, bus.alu_ctrl, bus.out_rd,
                         bus.out_wr_en, bus.out_store_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL areset_after got %0h want 0", bus.out_valid);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_stream();
    test_forward();
    test_load_use();
    test_stall_refresh();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
